uart: RTL and testbench
=======================

Name: uart

Overview:
- Self-contained 8N1 UART (start bit, 8 data bits, no parity, 1 stop bit) with internal loopback: the transmitter serialises dataIn onto txOutData, and the receiver deserialises that same txOutData internally and presents the byte on dataOut.
- Contains its own baud-tick generation from the system clock.
- Used as a self-test / bring-up block; txOutData may also drive a pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- TX_DIV, CLK_FREQ/BAUD (integer truncation, 5208), clocks per bit period.
- RX_DIV, CLK_FREQ/(BAUD*16) (integer truncation, 325), clocks per 16x oversample tick.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- transmit  input  1  level request; while high, frames are sent back-to-back.
- dataIn  input  8  byte to send; latched at frame start.
- dataOut  output  8  last correctly framed received byte.
- txOutData  output  1  serial line; idle high.
- txenable  output  1  one-cycle pulse per bit period (TX tick).
- rxenable  output  1  one-cycle pulse at 16x baud (RX oversample tick).

Behaviour:
- Reset (async, active-high):
  - All counters and state registers are cleared; TX and RX are forced to IDLE.
  - Outputs during reset: txOutData=1, dataOut=0, txenable=0, rxenable=0.
- Tick generation:
  - TX counter counts 0..TX_DIV-1 and wraps; txenable=1 for the single cycle where the counter equals TX_DIV-1.
  - RX counter does the same with RX_DIV, producing rxenable.
  - Both counters free-run from reset release, independently of transmit.
- TX FSM: IDLE, START, DATA, STOP. Transitions occur only on txenable cycles.
  - IDLE: line=1. On tick with transmit=1: latch dataIn into shift register, line=0, go to START. With transmit=0, stay in IDLE.
  - START: on tick, line=bit0 of latched byte, index=0, go to DATA.
  - DATA: on tick, if index<7 then index++ and drive the next bit (LSB first); if index==7, line=1 and go to STOP.
  - STOP: on tick, go to IDLE.
  - With transmit held high, a frame is 11 bit periods (start, 8 data, stop, 1 idle), i.e. 57288 clocks.
  - Changes to dataIn mid-frame have no effect on the frame in progress.
  - Deasserting transmit mid-frame completes the current frame.
- RX FSM: IDLE, START, DATA, STOP. Input is txOutData (internal loopback, no synchroniser). State advances only on rxenable cycles.
  - IDLE: on tick with line=0, clear sample count and go to START.
  - START: after 8 ticks (mid-bit), if line=0, clear count and go to DATA; else return to IDLE (glitch rejection).
  - DATA: every 16 ticks, sample the line into the shift register LSB-first. After 8 samples, go to STOP.
  - STOP: after 16 ticks, sample the line. If 1, dataOut <= shift register; if 0 (framing error), dataOut is unchanged. Either way, go to IDLE.
  - dataOut holds its value between frames.
- Reset mid-frame aborts both FSMs immediately; the line returns high and no partial byte is written to dataOut.
- Word widths: 8-bit data; 3-bit bit index; 4-bit oversample count; counter widths sized to ceil(log2(TX_DIV)) and ceil(log2(RX_DIV)).

Decomposition:
- Shared package uart_pkg holds:
  - TX/RX state enums: IDLE, START, DATA, STOP.
  - Frame constants: DATA_BITS=8, OVERSAMPLE=16.
  - Divisor computation functions.
- One sub-module is natural: uart_baud_gen (parameters CLK_FREQ, BAUD), producing txenable and rxenable.
- TX and RX FSMs stay in the top level.

Test Plan:
1. Reset held high for 10 cycles:
   - During reset: txOutData=1, dataOut=0x00, txenable=0, rxenable=0.
2. Tick check after reset release:
   - txenable pulses exactly every 5208 clocks, each pulse 1 cycle wide.
   - rxenable pulses every 325 clocks.
3. transmit=1, dataIn=0xBE from reset:
   - txOutData shows 0,0,1,1,1,1,1,0,1,1 (start, LSB-first 0xBE, stop), each level held 5208 clocks.
   - dataOut == 0xBE within 62500 clocks of reset release.
4. transmit held high for 6,000,000 clocks:
   - Frames repeat every 57288 clocks.
   - dataOut stays 0xBE; no spurious change.
5. Change dataIn to 0x55 mid-frame:
   - Current frame still carries 0xBE.
   - Next frame carries 0x55; dataOut becomes 0x55 after that frame.
6. Assert reset during DATA state:
   - txOutData goes to 1 immediately; dataOut=0.
   - After release, a full new frame is sent and received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, FSM state encodings and divisor helpers
//               for the loopback 8N1 UART.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame shape: 8 data bits, 16x receive oversampling
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int IDX_W      = $clog2(DATA_BITS);
    localparam int OS_W       = $clog2(OVERSAMPLE);

    // TX and RX share the same four-state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Clocks per bit period (truncating division)
    function automatic int calc_tx_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Clocks per oversample tick (truncating division)
    function automatic int calc_rx_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

    // Counter width able to hold 0..div-1, never narrower than one bit
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Free-running bit-rate (txenable) and 16x oversample
//               (rxenable) tick generators. Each tick is a single-cycle
//               pulse on the last count of its divider.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic clock,
    input  logic reset,
    output logic txenable,
    output logic rxenable
);

    localparam int TX_DIV   = calc_tx_div(CLK_FREQ, BAUD);
    localparam int RX_DIV   = calc_rx_div(CLK_FREQ, BAUD);
    localparam int TX_CNT_W = cnt_width(TX_DIV);
    localparam int RX_CNT_W = cnt_width(RX_DIV);

    localparam logic [TX_CNT_W-1:0] c_tx_last = TX_CNT_W'(TX_DIV - 1);
    localparam logic [RX_CNT_W-1:0] c_rx_last = RX_CNT_W'(RX_DIV - 1);

    logic [TX_CNT_W-1:0] r_tx_cnt;
    logic [RX_CNT_W-1:0] r_rx_cnt;
    logic                w_tx_wrap;
    logic                w_rx_wrap;

    // The tick is the wrap cycle itself; reset holds both counters at zero,
    // so neither tick can fire while reset is asserted.
    assign w_tx_wrap = (r_tx_cnt == c_tx_last);
    assign w_rx_wrap = (r_rx_cnt == c_rx_last);

    // Bit-period divider: counts 0..TX_DIV-1 and wraps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_cnt <= '0;
        end else if (w_tx_wrap) begin
            r_tx_cnt <= '0;
        end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end

    // Oversample divider: counts 0..RX_DIV-1 and wraps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_cnt <= '0;
        end else if (w_rx_wrap) begin
            r_rx_cnt <= '0;
        end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
        end
    end

    assign txenable = w_tx_wrap;
    assign rxenable = w_rx_wrap;

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart
// Description : 8N1 UART with internal loopback. The transmitter serialises
//               dataIn onto txOutData; the receiver oversamples that same
//               line and publishes correctly framed bytes on dataOut.
// Revision    : 1.0 - initial release
// ============================================================================
module uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 transmit,
    input  logic [DATA_BITS-1:0] dataIn,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 txOutData,
    output logic                 txenable,
    output logic                 rxenable
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DATA_BITS - 1);
    localparam logic [OS_W-1:0]  c_os_mid   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  c_os_last  = OS_W'(OVERSAMPLE - 1);

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    uart_baud_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud_gen (
        .clock    (clock),
        .reset    (reset),
        .txenable (txenable),
        .rxenable (rxenable)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [1:0]           r_tx_state;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [IDX_W-1:0]     r_tx_idx;
    logic                 r_tx_line;
    logic [IDX_W-1:0]     w_tx_next_idx;

    assign w_tx_next_idx = r_tx_idx + 1'b1;

    // TX FSM: every transition happens on a bit-period tick, so each line
    // level lasts exactly one bit period. The byte is captured at frame
    // start, which makes later dataIn changes invisible to that frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_shift <= '0;
            r_tx_idx   <= '0;
            r_tx_line  <= 1'b1;
        end else if (txenable) begin
            case (r_tx_state)
                ST_IDLE: begin
                    r_tx_line <= 1'b1;
                    if (transmit) begin
                        r_tx_shift <= dataIn;
                        r_tx_line  <= 1'b0;
                        r_tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_tx_line  <= r_tx_shift[0];
                    r_tx_idx   <= '0;
                    r_tx_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (r_tx_idx != c_last_idx) begin
                        r_tx_idx  <= w_tx_next_idx;
                        r_tx_line <= r_tx_shift[w_tx_next_idx];
                    end else begin
                        r_tx_line  <= 1'b1;
                        r_tx_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // One further idle period follows before the next start
                    r_tx_line  <= 1'b1;
                    r_tx_state <= ST_IDLE;
                end
                default: begin
                    r_tx_line  <= 1'b1;
                    r_tx_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign txOutData = r_tx_line;

    // ------------------------------------------------------------------
    // Receiver (loopback of the transmit line, no synchroniser needed
    // because the source is a register in this clock domain)
    // ------------------------------------------------------------------
    logic                 w_rx_line;
    logic [1:0]           r_rx_state;
    logic [OS_W-1:0]      r_rx_cnt;
    logic [IDX_W-1:0]     r_rx_idx;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 w_rx_stop_sample;
    logic                 w_rx_frame_ok;

    assign w_rx_line = r_tx_line;

    // Stop-bit sample point; a low stop bit is a framing error and is
    // dropped silently.
    assign w_rx_stop_sample = rxenable && (r_rx_state == ST_STOP) && (r_rx_cnt == c_os_last);
    assign w_rx_frame_ok    = w_rx_stop_sample && w_rx_line;

    // RX FSM: confirm the start bit at its centre, then sample every
    // sixteen ticks so each data and stop sample lands mid-bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
        end else if (rxenable) begin
            case (r_rx_state)
                ST_IDLE: begin
                    if (!w_rx_line) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_rx_cnt == c_os_mid) begin
                        if (!w_rx_line) begin
                            r_rx_cnt   <= '0;
                            r_rx_idx   <= '0;
                            r_rx_state <= ST_DATA;
                        end else begin
                            // Low pulse shorter than half a bit: ignore it
                            r_rx_state <= ST_IDLE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_rx_cnt == c_os_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_idx == c_last_idx) begin
                            r_rx_state <= ST_STOP;
                        end else begin
                            r_rx_idx <= r_rx_idx + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_rx_cnt == c_os_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= ST_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Received-byte holding register: only a well-framed byte replaces it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data_out <= '0;
        end else if (w_rx_frame_ok) begin
            r_data_out <= r_rx_shift;
        end
    end

    assign dataOut = r_data_out;

endmodule : uart
`default_nettype wire

// File: tb/tb_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart
// Description : Directed loopback test of the uart with a frame scoreboard.
//               Divisors are scaled down (TX_DIV=160, RX_DIV=10) so many
//               frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart;

    localparam int CLK_FREQ   = 1600000;
    localparam int BAUD       = 10000;
    localparam int TX_DIV     = CLK_FREQ / BAUD;
    localparam int RX_DIV     = CLK_FREQ / (BAUD * 16);
    localparam int FRAME_CLKS = 11 * TX_DIV;
    // Clocks the serial monitor spends from start detection to its dataOut check
    localparam int MON_SPAN   = TX_DIV / 2 + 9 * TX_DIV + TX_DIV / 2;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       transmit = 1'b0;
    logic [7:0] dataIn   = 8'h00;
    logic [7:0] dataOut;
    logic       txOutData;
    logic       txenable;
    logic       rxenable;

    always #5 clock = ~clock;

    uart #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .transmit  (transmit),
        .dataIn    (dataIn),
        .dataOut   (dataOut),
        .txOutData (txOutData),
        .txenable  (txenable),
        .rxenable  (rxenable)
    );

    int         n_assert    = 0;
    int         n_fail      = 0;
    logic [7:0] sb_q[$];
    logic [7:0] sb_last     = 8'h00;
    int         frames_done = 0;
    bit         period_en   = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tick monitor: interval between consecutive pulses, measured in clocks
    int cyc     = 0;
    int last_tx = 0;
    int last_rt = 0;
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (reset !== 1'b0) begin
                last_tx = cyc;
                last_rt = cyc;
            end else begin
                if (txenable === 1'b1) begin
                    check("tx_tick_period", cyc - last_tx, TX_DIV);
                    last_tx = cyc;
                end
                if (rxenable === 1'b1) begin
                    check("rx_tick_period", cyc - last_rt, RX_DIV);
                    last_rt = cyc;
                end
            end
        end
    end

    // Serial monitor: decodes txOutData at mid-bit and scores each frame
    bit         mon_abort;
    bit         mon_prev;
    int         mon_gap;
    logic [7:0] mon_got;
    logic [7:0] mon_exp;
    logic       mon_stop;

    task automatic mon_wait(input int n);
        for (int i = 0; i < n && !mon_abort; i++) begin
            @(negedge clock);
            if (reset !== 1'b0) mon_abort = 1'b1;
        end
    endtask

    initial begin
        mon_prev = 1'b0;
        mon_gap  = 0;
        forever begin
            while (reset !== 1'b0 || txOutData !== 1'b0) begin
                @(negedge clock);
                mon_gap++;
                if (reset !== 1'b0) mon_prev = 1'b0;
            end
            if (mon_prev && period_en)
                check("frame_period", mon_gap + MON_SPAN, FRAME_CLKS);
            mon_abort = 1'b0;
            mon_wait(TX_DIV / 2);
            if (!mon_abort) begin
                check("start_bit", 32'(txOutData), 0);
                check("rx_hold", 32'(dataOut), 32'(sb_last));
            end
            mon_got = 8'h00;
            for (int b = 0; b < 8; b++) begin
                mon_wait(TX_DIV);
                mon_got = {txOutData, mon_got[7:1]};
            end
            mon_wait(TX_DIV);
            mon_stop = txOutData;
            mon_wait(TX_DIV / 2);
            if (mon_abort) begin
                mon_prev = 1'b0;
            end else begin
                check("stop_bit", 32'(mon_stop), 1);
                if (sb_q.size() == 0) begin
                    check("sb_underflow", sb_q.size(), 1);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("tx_byte", 32'(mon_got), 32'(mon_exp));
                    check("rx_byte", 32'(dataOut), 32'(mon_exp));
                    sb_last = mon_exp;
                    frames_done++;
                end
                mon_prev = 1'b1;
            end
            mon_gap = 0;
        end
    end

    // Wait for the next bit-period tick, then step past its active edge
    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < TX_DIV + 4 && !found; i++) begin
            @(negedge clock);
            if (txenable === 1'b1) found = 1'b1;
        end
        check("tick_timeout", 32'(found), 1);
        @(posedge clock);
        #1;
    endtask

    // One back-to-back frame: 11 ticks starting with the latching tick
    task automatic send_frame(input logic [7:0] d, input bit chg, input logic [7:0] d2);
        dataIn = d;
        sb_q.push_back(d);
        wait_tick();
        if (chg) begin
            repeat (5) wait_tick();
            dataIn = d2;
            repeat (5) wait_tick();
        end else begin
            repeat (10) wait_tick();
        end
    endtask

    initial begin
        // Reset state
        reset    = 1'b1;
        transmit = 1'b1;
        dataIn   = 8'hBE;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("reset_line",    32'(txOutData), 1);
        check("reset_dataout", 32'(dataOut),   0);
        check("reset_txen",    32'(txenable),  0);
        check("reset_rxen",    32'(rxenable),  0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Continuous transmission of 0xBE
        for (int f = 0; f < 6; f++) send_frame(8'hBE, 1'b0, 8'h00);

        // dataIn changes mid-frame: this frame stays 0xBE, the next is 0x55
        send_frame(8'hBE, 1'b1, 8'h55);
        send_frame(8'h55, 1'b0, 8'h00);

        // Reset while the transmitter is in DATA (bit3 of 0xA7 is 0)
        dataIn = 8'hA7;
        sb_q.push_back(8'hA7);
        repeat (5) wait_tick();
        repeat (TX_DIV / 3) @(posedge clock);
        #3;
        check("mid_data_line", 32'(txOutData), 0);
        reset = 1'b1;
        #1;
        check("abort_line",    32'(txOutData), 1);
        check("abort_dataout", 32'(dataOut),   0);
        sb_q.delete();
        sb_last = 8'h00;
        dataIn  = 8'h3C;
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;

        // Full frame after reset
        send_frame(8'h3C, 1'b0, 8'h00);

        // transmit dropped mid-frame: frame completes, nothing follows
        dataIn = 8'hC3;
        sb_q.push_back(8'hC3);
        repeat (4) wait_tick();
        transmit  = 1'b0;
        period_en = 1'b0;
        dataIn    = 8'hFF;
        repeat (7) wait_tick();
        repeat (11) wait_tick();
        check("frames_done",   frames_done, 10);
        check("sb_drained",    sb_q.size(), 0);
        check("idle_line",     32'(txOutData), 1);
        check("final_dataout", 32'(dataOut), 32'h0000_00C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_uart
`default_nettype wire
